// File: rtl/cache_arbiter_if.sv
// Bundles the I-cache, D-cache and physical-memory sides of the line-fill arbiter.
// The arbiter uses the slave view; the clients and memory model use the master view.
interface cache_arbiter_if #(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 16
);
  logic                  i_pmem_read;
  logic [ADDR_WIDTH-1:0] i_pmem_address;
  logic [LINE_WIDTH-1:0] i_pmem_rdata;
  logic                  i_pmem_resp;

  logic                  d_pmem_read;
  logic                  d_pmem_write;
  logic [ADDR_WIDTH-1:0] d_pmem_address;
  logic [LINE_WIDTH-1:0] d_pmem_wdata;
  logic [LINE_WIDTH-1:0] d_pmem_rdata;
  logic                  d_pmem_resp;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    output i_pmem_rdata, i_pmem_resp,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output d_pmem_rdata, d_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    input  i_pmem_rdata, i_pmem_resp,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  d_pmem_rdata, d_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical memory port between I- and D-cache line fills/write-backs.
// Command registered one edge after grant; client resp is combinational with pmem_resp; one IDLE cycle per transaction.
module cache_arbiter #(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  cache_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_e;

  state_e                state_q, state_d;
  logic                  last_d_q, last_d_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

  logic                  i_resp, d_resp;
  logic [LINE_WIDTH-1:0] i_rdata, d_rdata;
  logic                  i_pend, d_pend, grant_i, grant_d;

  assign i_pend  = bus.i_pmem_read;
  assign d_pend  = bus.d_pmem_read | bus.d_pmem_write;
  // On a tie, the client that did not win last time gets the port.
  assign grant_i = i_pend & (~d_pend | last_d_q);
  assign grant_d = d_pend & ~grant_i;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    i_resp   = 1'b0;
    d_resp   = 1'b0;
    i_rdata  = '0;
    d_rdata  = '0;

    unique case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d  = SERVE_I;
          last_d_d = 1'b0;
          rd_d     = 1'b1;
          wr_d     = 1'b0;
          addr_d   = {bus.i_pmem_address[ADDR_WIDTH-1:4], 4'b0};
          wdata_d  = '0;
        end else if (grant_d) begin
          // A simultaneous read is dropped in favour of the write-back.
          state_d  = SERVE_D;
          last_d_d = 1'b1;
          rd_d     = ~bus.d_pmem_write;
          wr_d     = bus.d_pmem_write;
          addr_d   = {bus.d_pmem_address[ADDR_WIDTH-1:4], 4'b0};
          wdata_d  = bus.d_pmem_write ? bus.d_pmem_wdata : '0;
        end
      end
      SERVE_I: begin
        if (bus.pmem_resp) begin
          i_resp  = 1'b1;
          i_rdata = bus.pmem_rdata;
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      SERVE_D: begin
        if (bus.pmem_resp) begin
          d_resp  = 1'b1;
          d_rdata = bus.pmem_rdata;
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.pmem_read    = rd_q;
  assign bus.pmem_write   = wr_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;
  assign bus.i_pmem_resp  = i_resp;
  assign bus.i_pmem_rdata = i_rdata;
  assign bus.d_pmem_resp  = d_resp;
  assign bus.d_pmem_rdata = d_rdata;

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter: LINE_WIDTH, default 128, physical memory line width in bits.
REQ-002 Parameter: ADDR_WIDTH, default 16, byte address width.
REQ-003 Clock and reset: one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  in  1  synchronous active-low reset, sampled on clk rising edge.
REQ-006 i_pmem_read  in  1  I-cache line-fill request; held until i_pmem_resp.
REQ-007 i_pmem_address  in  ADDR_WIDTH  I-cache miss address.
REQ-008 i_pmem_rdata  out  LINE_WIDTH  fill data to I-cache.
REQ-009 i_pmem_resp  out  1  one-cycle completion pulse to I-cache.
REQ-010 d_pmem_read  in  1  D-cache line-fill request; held until d_pmem_resp.
REQ-011 d_pmem_write  in  1  D-cache write-back request; held until d_pmem_resp.
REQ-012 d_pmem_address  in  ADDR_WIDTH  D-cache miss/write-back address.
REQ-013 d_pmem_wdata  in  LINE_WIDTH  write-back line.
REQ-014 d_pmem_rdata  out  LINE_WIDTH  fill data to D-cache.
REQ-015 d_pmem_resp  out  1  one-cycle completion pulse to D-cache.
REQ-016 pmem_read / pmem_write  out  1 each  physical memory command, registered.
REQ-017 pmem_address  out  ADDR_WIDTH  line-aligned address, registered.
REQ-018 pmem_wdata  out  LINE_WIDTH  registered write line.
REQ-019 pmem_rdata  in  LINE_WIDTH; pmem_resp  in  1  memory data and completion.

Function
REQ-020 States: IDLE, SERVE_I, SERVE_D.
REQ-021 Pending: I when i_pmem_read; D when d_pmem_read or d_pmem_write.
REQ-022 IDLE, only I pending -> SERVE_I; only D pending -> SERVE_D; none -> stay IDLE.
REQ-023 IDLE, both pending -> grant the client NOT granted last (last_grant flag); last_grant resets to D, so the first tie goes to I.
REQ-024 On grant edge, latch: pmem_address = {client_addr[ADDR_WIDTH-1:4], 4'b0}; pmem_read/pmem_write from the granted client's command; pmem_wdata = d_pmem_wdata for D writes, else zero; last_grant updated.
REQ-025 Latched command, address and wdata are held constant throughout the SERVE state, regardless of input changes.
REQ-026 d_pmem_read and d_pmem_write both high: write takes precedence, and read is ignored for this grant.
REQ-027 In SERVE_x, on pmem_resp=1: x_pmem_resp=1 in the same cycle (combinational); x_pmem_rdata=pmem_rdata; next state IDLE; pmem_read/pmem_write cleared on that edge.
REQ-028 The non-granted client's resp stays 0 at all times; its rdata is driven to zero.
REQ-029 pmem_resp in IDLE is ignored and produces no client response.
REQ-030 A granted client dropping its request mid-transaction has no effect: the transaction completes, and resp is still pulsed.
REQ-031 Minimum latency: request seen in IDLE at edge N -> pmem command visible after edge N; a resp at cycle N+k completes; earliest regrant at edge N+k+1 (one IDLE cycle per transaction, which guarantees the requester deasserts).
REQ-032 No timeout; SERVE state waits indefinitely for pmem_resp.

Reset
REQ-033 reset_n=0 at a rising edge -> state IDLE, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, last_grant=D; i/d_pmem_resp=0, i/d_pmem_rdata=0.
REQ-034 Reset mid-transaction aborts the transaction immediately: no resp is issued, and a subsequent late pmem_resp is ignored.

Verification
REQ-035 Lone I fill at 0x1234, with memory resp 3 cycles later -> pmem_read=1, pmem_address=0x1230, i_pmem_resp pulses 1 cycle, and i_pmem_rdata matches pmem_rdata.
REQ-036 D write-back at 0x8F0A with wdata pattern A5..A5 -> pmem_write=1, address 0x8F00, pmem_wdata=pattern, d_pmem_resp pulses, and I sees no resp.
REQ-037 I and D asserted in the same cycle after reset -> I served first, then D, with exactly one IDLE cycle between them; with both requests repeating, grants alternate I, D, I, D.
REQ-038 d_pmem_read and d_pmem_write both high -> only pmem_write is asserted.
REQ-039 reset_n=0 during SERVE_D, followed by pmem_resp=1 -> no d_pmem_resp; all outputs at reset values; state IDLE.
REQ-040 Granted client's address changes mid-SERVE -> pmem_address remains at the latched value until completion.
